// File: rtl/stereo_arb_pkg.sv
// Shared types and defaults for the stereo line-read arbiter.
package stereo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

  localparam int unsigned DEF_LINE_LEN = 640;
  localparam int unsigned DEF_GAP      = 4;

  // Round-robin choice: lone requester wins; on a tie, serve the side not served last.
  function automatic logic pick_right(input logic l_pend, input logic r_pend, input logic last);
    return r_pend & (~l_pend | (last == SIDE_L));
  endfunction

endpackage

// File: rtl/arb_pending_flag.sv
// One-deep pending flag per camera side with sticky overflow; a new request wins over clears.
module arb_pending_flag (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic clr_i,
  input  logic clr_ovf_i,
  output logic pend_o,
  output logic ovf_o,
  output logic drop_o
);

  logic pend_q, pend_d;
  logic ovf_q, ovf_d;

  always_comb begin
    drop_o = req_i & pend_q & ~clr_i;
    pend_d = req_i | (pend_q & ~clr_i);
    ovf_d  = drop_o | (ovf_q & ~clr_ovf_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/stereo_line_read_arbiter.sv
// Round-robin arbiter sharing one line-buffer read path between left/right cameras.
// Optional per-side line counters and drop counter under STEREO_ARB_STATS_EN.
module stereo_line_read_arbiter
  import stereo_arb_pkg::*;
#(
  parameter int unsigned LINE_LEN = DEF_LINE_LEN,
  parameter int unsigned GAP      = DEF_GAP,
  parameter int unsigned CW       = 13
) (
  input  logic          CCD_PIXCLK,
  input  logic          RESET_SYS_N,
  input  logic          L_REQ,
  input  logic          R_REQ,
  input  logic          CLR_OVF,
  output logic          L_ACK,
  output logic          R_ACK,
  output logic          READ_EN,
  output logic [CW-1:0] READ_Cont,
  output logic          SEL_R,
  output logic          LINE_DONE,
  output logic          L_OVF,
  output logic          R_OVF
`ifdef STEREO_ARB_STATS_EN
  ,
  output logic [15:0]   L_LINES,
  output logic [15:0]   R_LINES,
  output logic [7:0]    DROP_CNT
`endif
);

  localparam logic [CW-1:0] LAST_COL = CW'(LINE_LEN - 1);
  localparam bit            HAS_GAP  = (GAP != 0);
  localparam logic [7:0]    GAP_LOAD = 8'(HAS_GAP ? GAP - 1 : 0);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    gap_q, gap_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic l_pend, r_pend, l_drop, r_drop;
  logic l_clr, r_clr, any_pend, pick_r, burst_end;

  // Flags clear on the edge leaving GRANT, so a request on that edge is a fresh line.
  assign l_clr     = (state_q == ST_GRANT) && (sel_q == SIDE_L);
  assign r_clr     = (state_q == ST_GRANT) && (sel_q == SIDE_R);
  assign any_pend  = l_pend | r_pend;
  assign pick_r    = pick_right(l_pend, r_pend, last_q);
  assign burst_end = (state_q == ST_BURST) && (col_q == LAST_COL);

  arb_pending_flag u_flag_l (
    .clk_i     (CCD_PIXCLK),
    .rst_ni    (RESET_SYS_N),
    .req_i     (L_REQ),
    .clr_i     (l_clr),
    .clr_ovf_i (CLR_OVF),
    .pend_o    (l_pend),
    .ovf_o     (L_OVF),
    .drop_o    (l_drop)
  );

  arb_pending_flag u_flag_r (
    .clk_i     (CCD_PIXCLK),
    .rst_ni    (RESET_SYS_N),
    .req_i     (R_REQ),
    .clr_i     (r_clr),
    .clr_ovf_i (CLR_OVF),
    .pend_o    (r_pend),
    .ovf_o     (R_OVF),
    .drop_o    (r_drop)
  );

  always_comb begin
    state_d = state_q;
    col_d   = '0;
    gap_d   = gap_q;
    sel_d   = sel_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (any_pend) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_BURST;
      ST_BURST: begin
        if (burst_end) begin
          done_d = 1'b1;
          if (HAS_GAP) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = any_pend ? ST_GRANT : ST_IDLE;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = any_pend ? ST_GRANT : ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_GRANT) begin
      sel_d  = pick_r;
      last_d = pick_r;
    end
  end

  always_ff @(posedge CCD_PIXCLK or negedge RESET_SYS_N) begin
    if (!RESET_SYS_N) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      gap_q   <= '0;
      sel_q   <= SIDE_L;
      last_q  <= SIDE_R;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign L_ACK     = l_clr;
  assign R_ACK     = r_clr;
  assign READ_EN   = (state_q == ST_BURST);
  assign READ_Cont = col_q;
  assign SEL_R     = sel_q;
  assign LINE_DONE = done_q;

`ifdef STEREO_ARB_STATS_EN
  logic [15:0] l_lines_q, r_lines_q;
  logic [7:0]  drop_q;
  logic        done_r_q;
  logic [8:0]  drop_sum;

  assign drop_sum = {1'b0, drop_q} + 9'(l_drop) + 9'(r_drop);

  // With GAP = 0 SEL_R may already point at the next side during LINE_DONE, so latch the finished side.
  always_ff @(posedge CCD_PIXCLK or negedge RESET_SYS_N) begin
    if (!RESET_SYS_N) begin
      l_lines_q <= '0;
      r_lines_q <= '0;
      drop_q    <= '0;
      done_r_q  <= 1'b0;
    end else begin
      if (burst_end) done_r_q <= sel_q;
      if (CLR_OVF) begin
        l_lines_q <= '0;
        r_lines_q <= '0;
        drop_q    <= 8'(l_drop) + 8'(r_drop);
      end else begin
        if (done_q && (done_r_q == SIDE_L)) l_lines_q <= l_lines_q + 1'b1;
        if (done_q && (done_r_q == SIDE_R)) r_lines_q <= r_lines_q + 1'b1;
        drop_q <= drop_sum[8] ? '1 : drop_sum[7:0];
      end
    end
  end

  assign L_LINES  = l_lines_q;
  assign R_LINES  = r_lines_q;
  assign DROP_CNT = drop_q;
`else
  logic unused_drop;
  assign unused_drop = l_drop ^ r_drop;
`endif

endmodule

// File: tb/tb_stereo_line_read_arbiter.sv
// Bench for stereo_line_read_arbiter: timeline model of grants plus directed literal checks.
module tb_stereo_line_read_arbiter;

  localparam int L = 8;
  localparam int G = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, lreq = 1'b0, rreq = 1'b0, clr = 1'b0;
  logic lack, rack, ren, sel, done, lovf, rovf;
  logic [12:0] cont;
  logic rst0_n = 1'b0, l0 = 1'b0, r0 = 1'b0;
  logic lack0, rack0, ren0, sel0, done0, lovf0, rovf0;
  logic [12:0] cont0;
`ifdef STEREO_ARB_STATS_EN
  logic [15:0] ll, rl, ll0, rl0;
  logic [7:0]  dc, dc0;
`endif

  stereo_line_read_arbiter #(.LINE_LEN(L), .GAP(G), .CW(13)) u_dut (
    .CCD_PIXCLK(clk), .RESET_SYS_N(rst_n), .L_REQ(lreq), .R_REQ(rreq), .CLR_OVF(clr),
    .L_ACK(lack), .R_ACK(rack), .READ_EN(ren), .READ_Cont(cont), .SEL_R(sel),
    .LINE_DONE(done), .L_OVF(lovf), .R_OVF(rovf)
`ifdef STEREO_ARB_STATS_EN
    , .L_LINES(ll), .R_LINES(rl), .DROP_CNT(dc)
`endif
  );

  stereo_line_read_arbiter #(.LINE_LEN(4), .GAP(0), .CW(13)) u_dut0 (
    .CCD_PIXCLK(clk), .RESET_SYS_N(rst0_n), .L_REQ(l0), .R_REQ(r0), .CLR_OVF(1'b0),
    .L_ACK(lack0), .R_ACK(rack0), .READ_EN(ren0), .READ_Cont(cont0), .SEL_R(sel0),
    .LINE_DONE(done0), .L_OVF(lovf0), .R_OVF(rovf0)
`ifdef STEREO_ARB_STATS_EN
    , .L_LINES(ll0), .R_LINES(rl0), .DROP_CNT(dc0)
`endif
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a grant at cycle g owns cycles g..g+L+1; the next decision is taken at g+L+G.
  bit pl, pr, ovl, ovr, last, msel, have_g;
  int g, gside, next_dec;

  always @(posedge clk) begin
    bit cl, cr, dl, dr;
    cyc = cyc + 1;
    if (!rst_n) begin
      pl = 0; pr = 0; ovl = 0; ovr = 0; last = 1; msel = 0; have_g = 0; next_dec = cyc;
    end else begin
      cl = have_g && (g == cyc - 1) && (gside == 0);
      cr = have_g && (g == cyc - 1) && (gside == 1);
      if ((cyc - 1 >= next_dec) && (pl || pr)) begin
        gside = (pr && (!pl || last == 1'b0)) ? 1 : 0;
        g = cyc; have_g = 1; last = (gside == 1); msel = last;
        next_dec = cyc + L + G;
      end
      dl = lreq && pl && !cl;
      dr = rreq && pr && !cr;
      pl = lreq || (pl && !cl);
      pr = rreq || (pr && !cr);
      ovl = dl || (ovl && !clr);
      ovr = dr || (ovr && !clr);
    end
  end

  always @(negedge clk) begin
    int e_la, e_ra, e_en, e_ct, e_dn, e_sel, e_ol, e_or;
    e_la = 0; e_ra = 0; e_en = 0; e_ct = 0; e_dn = 0; e_sel = 0; e_ol = 0; e_or = 0;
    if (rst_n) begin
      e_la  = (have_g && cyc == g && gside == 0) ? 1 : 0;
      e_ra  = (have_g && cyc == g && gside == 1) ? 1 : 0;
      e_en  = (have_g && cyc >= g + 1 && cyc <= g + L) ? 1 : 0;
      e_ct  = e_en ? cyc - g - 1 : 0;
      e_dn  = (have_g && cyc == g + L + 1) ? 1 : 0;
      e_sel = msel ? 1 : 0;
      e_ol  = ovl ? 1 : 0;
      e_or  = ovr ? 1 : 0;
    end
    chk("model L_ACK", 32'(lack), e_la);
    chk("model R_ACK", 32'(rack), e_ra);
    chk("model READ_EN", 32'(ren), e_en);
    chk("model READ_Cont", 32'(cont), e_ct);
    chk("model LINE_DONE", 32'(done), e_dn);
    chk("model SEL_R", 32'(sel), e_sel);
    chk("model L_OVF", 32'(lovf), e_ol);
    chk("model R_OVF", 32'(rovf), e_or);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic to_cycle(input int k);
    @(negedge clk);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic do_reset();
    step(); rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_ack(input string nm, input bit want_r, output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (want_r ? rack : lack) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk({nm, " timeout"}, 32'(0), 1);
  endtask

  task automatic wait_any(output int at, output int side);
    at = -1; side = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lack || rack) begin
        at = cyc; side = rack ? 1 : 0;
        break;
      end
    end
    if (at < 0) chk("any ACK timeout", 32'(0), 1);
  endtask

  initial begin
    int c0, g1, g2, s, nl;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset READ_EN", 32'(ren), 0);
    chk("reset SEL_R", 32'(sel), 0);
    chk("reset LINE_DONE", 32'(done), 0);
    step(); rst_n = 1'b1;
    step(); step();

    // Single left request
    step(); lreq = 1'b1; step(); lreq = 1'b0; c0 = cyc;
    to_cycle(c0 + 1); chk("t1 L_ACK", 32'(lack), 1); chk("t1 SEL_R", 32'(sel), 0);
    to_cycle(c0 + 2); chk("t1 READ_EN first", 32'(ren), 1); chk("t1 col first", 32'(cont), 0);
    to_cycle(c0 + 9); chk("t1 col last", 32'(cont), 7);
    to_cycle(c0 + 10); chk("t1 LINE_DONE", 32'(done), 1); chk("t1 col after", 32'(cont), 0);
    to_cycle(c0 + 14);

    // Simultaneous requests straight after reset: left first
    do_reset();
    lreq = 1'b1; rreq = 1'b1; step(); lreq = 1'b0; rreq = 1'b0; c0 = cyc;
    to_cycle(c0 + 1); chk("t2 L_ACK", 32'(lack), 1);
    to_cycle(c0 + 11); chk("t2 gap idle", 32'(ren), 0);
    to_cycle(c0 + 12); chk("t2 R_ACK", 32'(rack), 1); chk("t2 SEL_R", 32'(sel), 1);
    to_cycle(c0 + 24);

    // Fairness over ten lines
    step(); clr = 1'b1; step(); clr = 1'b0;
    lreq = 1'b1; rreq = 1'b1; step(); lreq = 1'b0; rreq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_any(g1, s);
      chk("fair order", 32'(s), i % 2);
      if (i < 8) begin
        step(); step();
        if (s == 1) rreq = 1'b1; else lreq = 1'b1;
        step(); rreq = 1'b0; lreq = 1'b0;
      end
    end
    repeat (20) step();
`ifdef STEREO_ARB_STATS_EN
    @(negedge clk);
    chk("fair L_LINES", 32'(ll), 5);
    chk("fair R_LINES", 32'(rl), 5);
`endif

    // Overflow: two left requests inside one right burst
    step(); rreq = 1'b1; step(); rreq = 1'b0;
    wait_ack("t4 R_ACK", 1'b1, g1);
    step(); lreq = 1'b1; step(); lreq = 1'b0;
    step(); lreq = 1'b1; step(); lreq = 1'b0;
    @(negedge clk); chk("t4 L_OVF set", 32'(lovf), 1);
`ifdef STEREO_ARB_STATS_EN
    chk("t4 DROP_CNT", 32'(dc), 1);
`endif
    nl = 0;
    repeat (40) begin
      @(negedge clk);
      if (lack) nl++;
    end
    chk("t4 left bursts", 32'(nl), 1);
    chk("t4 L_OVF sticky", 32'(lovf), 1);
    step(); clr = 1'b1; step(); clr = 1'b0;
    @(negedge clk); chk("t4 L_OVF cleared", 32'(lovf), 0);
    repeat (3) step();

    // Request on the left GRANT exit edge is a new line
    lreq = 1'b1; step(); lreq = 1'b0;
    wait_ack("t5 L_ACK1", 1'b0, g1);
    lreq = 1'b1; step(); lreq = 1'b0;
    wait_ack("t5 L_ACK2", 1'b0, g2);
    chk("t5 regrant spacing", 32'(g2 - g1), L + G + 1);
    chk("t5 no L_OVF", 32'(lovf), 0);
    repeat (14) step();

    // Reset mid-burst on the GAP=2 instance
    lreq = 1'b1; step(); lreq = 1'b0;
    wait_ack("t6 L_ACK", 1'b0, g1);
    step(); step(); step();
    rst_n = 1'b0; #1;
    chk("t6 READ_EN async", 32'(ren), 0);
    chk("t6 READ_Cont async", 32'(cont), 0);
    step(); step(); rst_n = 1'b1;
    repeat (15) step();

    // GAP=0 instance: back-to-back grants, then reset mid-burst
    rst0_n = 1'b1; step();
    l0 = 1'b1; r0 = 1'b1; step(); l0 = 1'b0; r0 = 1'b0; c0 = cyc;
    to_cycle(c0 + 1); chk("g0 L_ACK", 32'(lack0), 1);
    to_cycle(c0 + 5); chk("g0 READ_EN last", 32'(ren0), 1); chk("g0 col last", 32'(cont0), 3);
    chk("g0 SEL_R left", 32'(sel0), 0);
    to_cycle(c0 + 6); chk("g0 R_ACK direct", 32'(rack0), 1); chk("g0 LINE_DONE", 32'(done0), 1);
    chk("g0 READ_EN off", 32'(ren0), 0); chk("g0 SEL_R right", 32'(sel0), 1);
    to_cycle(c0 + 7); chk("g0 R col0", 32'(cont0), 0); chk("g0 R READ_EN", 32'(ren0), 1);
    to_cycle(c0 + 8); chk("g0 R col1", 32'(cont0), 1);
    #1 rst0_n = 1'b0; #1;
    chk("g0 rst READ_EN", 32'(ren0), 0);
    chk("g0 rst READ_Cont", 32'(cont0), 0);
    chk("g0 rst SEL_R", 32'(sel0), 0);
    repeat (6) begin
      @(negedge clk);
      chk("g0 no LINE_DONE", 32'(done0), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
